// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit 7-segment history display.
// Segment patterns are active-low, bit order gfedcba.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned HIST_DEPTH = NUM_DIGITS - 1;

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_FLASH  = 2'd1,
        ST_FROZEN = 2'd2
    } disp_state_e;

    function automatic logic [6:0] hex_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment decoder (gfedcba).
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_seg(nibble_i);

endmodule

// File: rtl/hex_history_display.sv
// Drives HEX0 with the current value and HEX1..HEX3 with the three previous
// distinct values; HEX0 flashes after each change and a freeze switch holds all.
module hex_history_display
    import display_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic       freeze,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       changed
);

    localparam int unsigned CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    disp_state_e      state_q, state_d;
    logic [3:0]       cur_q, cur_d;
    logic [3:0]       hist_q [HIST_DEPTH];
    logic [3:0]       hist_d [HIST_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             changed_q, changed_d;
    logic [6:0]       hex_q [NUM_DIGITS];
    logic [6:0]       hex_d [NUM_DIGITS];

    logic [3:0]       digit_d [NUM_DIGITS];
    logic [6:0]       seg_d   [NUM_DIGITS];
    logic             is_change;
    logic             blank_d;

    assign is_change = (data_in != cur_q);

    // Freeze is checked before a pending change so it always wins.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        hist_d    = hist_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        changed_d = 1'b0;

        case (state_q)
            ST_STABLE, ST_FLASH: begin
                if (freeze) begin
                    state_d = ST_FROZEN;
                    cnt_d   = '0;
                    phase_d = 2'd0;
                end else if (is_change) begin
                    hist_d[2]  = hist_q[1];
                    hist_d[1]  = hist_q[0];
                    hist_d[0]  = cur_q;
                    cur_d      = data_in;
                    changed_d  = 1'b1;
                    state_d    = ST_FLASH;
                    cnt_d      = '0;
                    phase_d    = 2'd0;
                end else if (state_q == ST_FLASH) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (phase_q == 2'd3) begin
                            state_d = ST_STABLE;
                            phase_d = 2'd0;
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FROZEN: begin
                // Release only changes state; a pending difference is taken next cycle.
                if (!freeze) begin
                    state_d = ST_STABLE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
                phase_d = 2'd0;
            end
        endcase
    end

    assign digit_d[0] = cur_d;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_hist_digit
            assign digit_d[gi] = hist_d[gi-1];
        end

        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decode
            hex_to_seg u_hex_to_seg (
                .nibble_i (digit_d[gi]),
                .seg_o    (seg_d[gi])
            );
        end
    endgenerate

    // Outputs are decoded from next-state values so they line up with the state registers.
    assign blank_d  = (state_d == ST_FLASH) && phase_d[0];
    assign hex_d[0] = blank_d ? SEG_BLANK : seg_d[0];

    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_hex_next
            assign hex_d[gi] = seg_d[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STABLE;
            cur_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= 2'd0;
            changed_q <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= SEG_ZERO;
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            changed_q <= changed_d;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign hex0    = hex_q[0];
    assign hex1    = hex_q[1];
    assign hex2    = hex_q[2];
    assign hex3    = hex_q[3];
    assign changed = changed_q;

endmodule

// File: tb/tb_hex_history_display.sv
// Directed bench for hex_history_display with a queue/age based reference model
// compared on every falling edge, plus literal spot checks.
module tb_hex_history_display;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_in;
    logic       freeze;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       changed;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit cmp_en = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: last four distinct values (newest first), cycles since last accepted change.
    logic [3:0] m_vals [$] = '{4'h0, 4'h0, 4'h0, 4'h0};
    int         m_age      = -1;
    bit         m_frozen   = 0;
    bit         m_changed  = 0;

    hex_history_display #(.BLINK_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .freeze  (freeze),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .changed (changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vals    = '{4'h0, 4'h0, 4'h0, 4'h0};
            m_age     = -1;
            m_frozen  = 0;
            m_changed = 0;
        end else begin
            m_changed = 0;
            if (m_frozen) begin
                if (!freeze) m_frozen = 0;
            end else if (freeze) begin
                m_frozen = 1;
                m_age    = -1;
            end else if (data_in != m_vals[0]) begin
                m_vals.push_front(data_in);
                void'(m_vals.pop_back());
                m_age     = 0;
                m_changed = 1;
            end else if (m_age >= 0) begin
                m_age++;
                if (m_age >= 4 * DIV) m_age = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] e0;
        if (cmp_en) begin
            e0 = (m_age >= 0 && ((m_age / DIV) % 2) == 1) ? 7'h7F : seg_tab[m_vals[0]];
            chk("model_hex0", hex0, e0);
            chk("model_hex1", hex1, seg_tab[m_vals[1]]);
            chk("model_hex2", hex2, seg_tab[m_vals[2]]);
            chk("model_hex3", hex3, seg_tab[m_vals[3]]);
            chk("model_changed", {6'b0, changed}, {6'b0, m_changed});
            if (changed === 1'b1) pulses++;
        end
    end

    initial begin
        rst_n   = 1'b0;
        data_in = 4'h0;
        freeze  = 1'b0;
        tick(3);
        cmp_en = 1;
        chk("reset_hex0", hex0, 7'h40);
        chk("reset_hex3", hex3, 7'h40);
        chk("reset_changed", {6'b0, changed}, 7'h00);
        rst_n = 1'b1;

        // Idle after reset
        tick(10);
        chk("idle_hex0", hex0, 7'h40);
        chk("idle_hex1", hex1, 7'h40);
        chk("idle_pulses", 7'(pulses), 7'd0);

        // 0 -> 5 and the flash pattern
        data_in = 4'h5;
        tick(1);
        chk("chg5_hex0", hex0, 7'h12);
        chk("chg5_hex1", hex1, 7'h40);
        chk("chg5_changed", {6'b0, changed}, 7'h01);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("flash5_k%0d", k), hex0, (((k / 4) % 2) == 1) ? 7'h7F : 7'h12);
            tick(1);
        end
        chk("flash5_done", hex0, 7'h12);
        chk("flash5_nochg", {6'b0, changed}, 7'h00);

        // Sequence 1, 2, 3, A
        data_in = 4'h1; tick(20);
        data_in = 4'h2; tick(20);
        data_in = 4'h3; tick(20);
        data_in = 4'hA; tick(20);
        chk("seq_hex0", hex0, 7'h08);
        chk("seq_hex1", hex1, 7'h30);
        chk("seq_hex2", hex2, 7'h24);
        chk("seq_hex3", hex3, 7'h79);
        chk("seq_pulses", 7'(pulses), 7'd5);

        // Change during phase 2 restarts the flash
        data_in = 4'h5; tick(20);
        data_in = 4'h6; tick(1);
        tick(8);
        chk("ph2_hex0", hex0, 7'h02);
        data_in = 4'h7; tick(1);
        chk("restart_hex0", hex0, 7'h78);
        chk("restart_hex1", hex1, 7'h02);
        chk("restart_hex2", hex2, 7'h12);
        chk("restart_hex3", hex3, 7'h08);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("flash7_k%0d", k), hex0, (((k / 4) % 2) == 1) ? 7'h7F : 7'h78);
            tick(1);
        end
        chk("flash7_done", hex0, 7'h78);
        chk("restart_pulses", 7'(pulses), 7'd8);

        // Freeze holds everything while data changes
        freeze = 1'b1; tick(2);
        data_in = 4'hF; tick(10);
        chk("frozen_hex0", hex0, 7'h78);
        chk("frozen_pulses", 7'(pulses), 7'd8);
        freeze = 1'b0; tick(1);
        chk("release_nochg", {6'b0, changed}, 7'h00);
        chk("release_hex0", hex0, 7'h78);
        tick(1);
        chk("release_changed", {6'b0, changed}, 7'h01);
        chk("release_hexF", hex0, 7'h0E);
        chk("release_hex1", hex1, 7'h78);

        // Freeze in the same cycle as a change, while HEX0 is blanked
        tick(5);
        chk("blank_before_frz", hex0, 7'h7F);
        data_in = 4'h9;
        freeze  = 1'b1;
        tick(1);
        chk("frzwin_hex0", hex0, 7'h0E);
        chk("frzwin_changed", {6'b0, changed}, 7'h00);
        chk("frzwin_hex1", hex1, 7'h78);
        tick(5);
        chk("frzwin_hold", hex0, 7'h0E);
        freeze = 1'b0;
        tick(2);
        chk("after_frz_hex0", hex0, 7'h10);
        chk("after_frz_changed", {6'b0, changed}, 7'h01);

        // Asynchronous reset during flash phase 1
        tick(20);
        data_in = 4'h4; tick(1);
        tick(5);
        chk("ph1_blank", hex0, 7'h7F);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hex0", hex0, 7'h40);
        chk("arst_hex1", hex1, 7'h40);
        chk("arst_hex2", hex2, 7'h40);
        chk("arst_hex3", hex3, 7'h40);
        chk("arst_changed", {6'b0, changed}, 7'h00);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("final_hex0", hex0, 7'h19);
        chk("final_hex1", hex1, 7'h40);
        chk("final_pulses", 7'(pulses), 7'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_history_display.md
# hex_history_display

Output stage of the DE0 lab design. Takes the 4-bit value produced by the buffer/logic stage and drives the four on-board 7-segment digits. HEX0 shows the current value; HEX1–HEX3 show the three previous distinct values as a shift history. HEX0 flashes briefly after every change, and a freeze switch holds the whole display.

## Interface
- BLINK_DIV, default 25_000_000: clk cycles per flash half-period (0.5 s at 50 MHz); legal range ≥ 2.
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset; asynchronous, active-low
- data_in  input  4  value from upstream stage, level signal in the clk domain
- freeze  input  1  level; high = display held, data_in ignored (already debounced)
- hex0  output  7  current value, active-low, bit order gfedcba
- hex1  output  7  previous value
- hex2  output  7  value before hex1
- hex3  output  7  oldest value
- changed  output  1  one-cycle pulse on every accepted change

## Operation
- State: cur_reg[3:0], hist0/1/2[3:0], FSM state, half-period counter, flash phase counter (2 bits).
- Change accepted when data_in != cur_reg and FSM is not in FROZEN.
  - On acceptance: hist2←hist1, hist1←hist0, hist0←cur_reg, cur_reg←data_in; changed=1 for that cycle.
- FSM states:
  - ST_STABLE: all digits show their values.
    - Change → ST_FLASH.
    - freeze=1 → ST_FROZEN.
  - ST_FLASH: HEX0 blanked (7'h7F) during odd flash phases (1, 3) and shown during even phases (0, 2).
    - Half-period counter counts 0..BLINK_DIV-1; on wrap, phase increments.
    - After phase 3 wraps → ST_STABLE.
    - New change in ST_FLASH: history shifts, counter and phase restart at 0, state stays ST_FLASH.
  - ST_FROZEN: all outputs held, no shifts, changed=0, HEX0 solid.
    - freeze=0 → ST_STABLE. Any data_in ≠ cur_reg is then accepted as a change on the following cycle.
- Priority when freeze rises in the same cycle as a change: freeze wins. The change is not accepted and the state goes to ST_FROZEN; flash is aborted.
- Segment encoding, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - Blank = 7F.
- Reset values:
  - cur_reg = 0, hist = 0.
  - hex0–hex3 = 7'h40 (all show "0").
  - changed = 0.
  - State ST_STABLE; counters = 0.
- Reset mid-flash or while frozen: immediate return to the reset values above.

## Timing
- All outputs are registered.
- Change present on data_in at edge N:
  - changed is high during cycle N+1 only.
  - hex0–hex3 show the new values from N+1 (hex0 shows the new value, phase 0).
- Flash duration: exactly 4×BLINK_DIV cycles from the accepting edge. HEX0 is blank for the cycles of phases 1 and 3.
- Freeze takes effect on the edge after it is sampled high; release is the same.
- Upstream value held constant for many cycles: only one shift and one changed pulse.

## Structure
- Package display_pkg:
  - SEG_BLANK = 7'h7F.
  - State encodings ST_STABLE/ST_FLASH/ST_FROZEN (2-bit).
  - Function or constant table for the hex→segment map.
- Sub-module hex_to_seg: combinational 4→7 decoder, instantiated four times.
- Top block contains the history registers, the FSM, the counters and the output registers.
- Remaining RTL is roughly 150–250 lines.

## Test plan
All scenarios run with BLINK_DIV=4.
- Reset, then idle → hex0–hex3 = 40, changed never pulses.
- data_in 0→5 at edge N → changed at N+1; hex0=12, hex1=40.
  - HEX0 cycles show/blank in 4-cycle phases (12, 7F, 12, 7F), then solid 12 after 16 cycles.
- Sequence 1, 2, 3, A, each held 20 cycles → final hex0=08, hex1=30, hex2=24, hex3=79; 4 changed pulses.
- Change 5→6 at phase 2, then 6→7 → history 7/6/5 shifts correctly; flash restarts at phase 0 with 16 further cycles.
- freeze=1, then data_in to F for 10 cycles → no change and no pulse.
  - freeze=0 → one cycle later changed pulses and hex0=0E.
- Freeze asserted in the same cycle as a change → change rejected, FROZEN entered, hex0 solid with the old value.
- rst_n low during ST_FLASH phase 1 → outputs immediately 40/0, state ST_STABLE.
